// File: rtl/dffram_wb_ctrl_if.sv
// Wishbone Classic bus bundle for the DFFRAM controller.
// Slave side is the RAM controller, master side the interconnect.
interface dffram_wb_ctrl_if #(
   parameter int AW = 9,
   parameter int SW = 4
);
   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [SW-1:0]     wb_sel_i;
   logic [AW+1:0]     wb_adr_i;
   logic [8*SW-1:0]   wb_dat_i;
   logic [8*SW-1:0]   wb_dat_o;
   logic              wb_ack_o;

   modport slave (
      input  wb_cyc_i,
      input  wb_stb_i,
      input  wb_we_i,
      input  wb_sel_i,
      input  wb_adr_i,
      input  wb_dat_i,
      output wb_dat_o,
      output wb_ack_o
   );

   modport master (
      output wb_cyc_i,
      output wb_stb_i,
      output wb_we_i,
      output wb_sel_i,
      output wb_adr_i,
      output wb_dat_i,
      input  wb_dat_o,
      input  wb_ack_o
   );
endinterface

// File: rtl/dffram_wb_ctrl.sv
// Wishbone Classic front-end for one 512x32 DFFRAM bank.
// Issues one registered RAM strobe per transfer, acks 3 cycles later.
module dffram_wb_ctrl #(
   parameter int AW = 9,
   parameter int SW = 4
) (
   input  logic              CLK,
   input  logic              RST,
   dffram_wb_ctrl_if.slave   wb,
   output logic              EN0,
   output logic [SW-1:0]     WE0,
   output logic [AW-1:0]     A0,
   output logic [8*SW-1:0]   Di0,
   input  logic [8*SW-1:0]   Do0
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] ACK     = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              en_q, en_d;
   logic [SW-1:0]     we_q, we_d;
   logic [AW-1:0]     a_q, a_d;
   logic [8*SW-1:0]   di_q, di_d;
   logic [8*SW-1:0]   dat_q, dat_d;
   logic              ack_q, ack_d;
   logic              rd_q, rd_d;
   logic              req;

   // byte offset never reaches the word-addressed RAM
   logic              unused_adr;
   assign unused_adr = ^wb.wb_adr_i[1:0];

   assign req = wb.wb_cyc_i & wb.wb_stb_i;

   // next-state: accept in IDLE, strobe once, capture, then ack
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      we_d    = we_q;
      a_d     = a_q;
      di_d    = di_q;
      dat_d   = dat_q;
      rd_d    = rd_q;
      ack_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            en_d = 1'b0;
            we_d = '0;
            if (req) begin
               a_d     = wb.wb_adr_i[AW+1:2];
               di_d    = wb.wb_dat_i;
               we_d    = wb.wb_we_i ? wb.wb_sel_i : '0;
               en_d    = 1'b1;
               rd_d    = ~wb.wb_we_i;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            en_d    = 1'b0;
            we_d    = '0;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (rd_q) dat_d = Do0;
            if (wb.wb_cyc_i) begin
               ack_d   = 1'b1;
               state_d = ACK;
            end else begin
               state_d = IDLE;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers, reset wins over any request
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         we_q    <= '0;
         a_q     <= '0;
         di_q    <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         we_q    <= we_d;
         a_q     <= a_d;
         di_q    <= di_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         rd_q    <= rd_d;
      end
   end

   assign EN0         = en_q;
   assign WE0         = we_q;
   assign A0          = a_q;
   assign Di0         = di_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_ack_o = ack_q;
endmodule

// File: tb/tb_dffram_wb_ctrl.sv
// Directed bench for dffram_wb_ctrl with a behavioural DFFRAM model.
// Checks strobes, latency, byte lanes, back-to-back, abort and reset.
module tb_dffram_wb_ctrl;
   logic          CLK;
   logic          RST;
   logic          EN0;
   logic [3:0]    WE0;
   logic [8:0]    A0;
   logic [31:0]   Di0;
   logic [31:0]   Do0;

   int n_assert;
   int n_fail;
   int en_cnt;
   int ack_cnt;
   logic [31:0] held;

   logic [31:0] mem [512];

   dffram_wb_ctrl_if #(.AW(9), .SW(4)) wb ();

   dffram_wb_ctrl #(.AW(9), .SW(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .wb  (wb),
      .EN0 (EN0),
      .WE0 (WE0),
      .A0  (A0),
      .Di0 (Di0),
      .Do0 (Do0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RAM: acts on the edge ending an EN0 cycle, Do0 held until next EN0
   always @(posedge CLK) begin
      if (EN0) begin
         for (int b = 0; b < 4; b++)
            if (WE0[b]) mem[A0][b*8 +: 8] <= Di0[b*8 +: 8];
         Do0 <= mem[A0];
      end
   end

   always @(posedge CLK) begin
      if (EN0) en_cnt++;
      if (wb.wb_ack_o) ack_cnt++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we,
                        input logic [3:0] sel,
                        input logic [10:0] adr,
                        input logic [31:0] dat);
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_sel_i = sel;
      wb.wb_adr_i = adr;
      wb.wb_dat_i = dat;
   endtask

   task automatic idle_bus();
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      wb.wb_sel_i = 4'h0;
   endtask

   task automatic xfer(input string tag,
                       input logic we,
                       input logic [3:0] sel,
                       input logic [10:0] adr,
                       input logic [31:0] dat,
                       input logic [3:0] exp_we0,
                       input logic [8:0] exp_a0,
                       input logic [31:0] exp_dat,
                       input bit hold);
      int en0;
      int ak0;
      en0 = en_cnt;
      ak0 = ack_cnt;
      drive(we, sel, adr, dat);
      tick();
      chk({tag, ".issue_en0"}, 32'(EN0), 32'd1);
      chk({tag, ".issue_we0"}, 32'(WE0), 32'(exp_we0));
      chk({tag, ".issue_a0"}, 32'(A0), 32'(exp_a0));
      chk({tag, ".issue_ack"}, 32'(wb.wb_ack_o), 32'd0);
      if (we) chk({tag, ".issue_di0"}, Di0, dat);
      tick();
      chk({tag, ".cap_en0"}, 32'(EN0), 32'd0);
      chk({tag, ".cap_ack"}, 32'(wb.wb_ack_o), 32'd0);
      tick();
      chk({tag, ".ack"}, 32'(wb.wb_ack_o), 32'd1);
      chk({tag, ".dat"}, wb.wb_dat_o, exp_dat);
      tick();
      if (!hold) idle_bus();
      chk({tag, ".ack_off"}, 32'(wb.wb_ack_o), 32'd0);
      chk({tag, ".en_pulses"}, 32'(en_cnt - en0), 32'd1);
      chk({tag, ".acks"}, 32'(ack_cnt - ak0), 32'd1);
   endtask

   initial begin
      int ak0;
      n_assert = 0;
      n_fail   = 0;
      en_cnt   = 0;
      ack_cnt  = 0;
      held     = 32'h0;
      wb.wb_adr_i = '0;
      wb.wb_dat_i = '0;
      idle_bus();

      // reset while a request is pending: must not be accepted
      RST = 1'b1;
      drive(1'b1, 4'hF, 11'h010, 32'h12345678);
      tick();
      tick();
      tick();
      chk("rst.en0", 32'(EN0), 32'd0);
      chk("rst.we0", 32'(WE0), 32'd0);
      chk("rst.a0", 32'(A0), 32'd0);
      chk("rst.di0", Di0, 32'd0);
      chk("rst.dat", wb.wb_dat_o, 32'd0);
      chk("rst.ack", 32'(wb.wb_ack_o), 32'd0);
      idle_bus();
      RST = 1'b0;
      tick();
      chk("rst.enpulses", 32'(en_cnt), 32'd0);

      // basic write then read
      xfer("wr1", 1'b1, 4'hF, 11'h010, 32'hDEADBEEF,
           4'hF, 9'd4, held, 1'b0);
      xfer("rd1", 1'b0, 4'hF, 11'h010, 32'h0,
           4'h0, 9'd4, 32'hDEADBEEF, 1'b0);
      held = 32'hDEADBEEF;

      // partial byte-lane write
      xfer("fill20", 1'b1, 4'hF, 11'h020, 32'h11223344,
           4'hF, 9'd8, held, 1'b0);
      xfer("lane20", 1'b1, 4'b0101, 11'h020, 32'hAABBCCDD,
           4'b0101, 9'd8, held, 1'b0);
      xfer("rd20", 1'b0, 4'hF, 11'h020, 32'h0,
           4'h0, 9'd8, 32'h11BB33DD, 1'b0);
      held = 32'h11BB33DD;

      // back-to-back reads with the request held through ack
      xfer("fill000", 1'b1, 4'hF, 11'h000, 32'hA0000000,
           4'hF, 9'd0, held, 1'b0);
      xfer("fill004", 1'b1, 4'hF, 11'h004, 32'hA1111111,
           4'hF, 9'd1, held, 1'b0);
      xfer("fill7fc", 1'b1, 4'hF, 11'h7FC, 32'hA2222222,
           4'hF, 9'd511, held, 1'b0);
      ak0 = ack_cnt;
      xfer("b2b0", 1'b0, 4'hF, 11'h000, 32'h0,
           4'h0, 9'd0, 32'hA0000000, 1'b1);
      xfer("b2b1", 1'b0, 4'hF, 11'h004, 32'h0,
           4'h0, 9'd1, 32'hA1111111, 1'b1);
      xfer("b2b2", 1'b0, 4'hF, 11'h7FC, 32'h0,
           4'h0, 9'd511, 32'hA2222222, 1'b0);
      chk("b2b.acks", 32'(ack_cnt - ak0), 32'd3);
      held = 32'hA2222222;

      // write aborted during ISSUE: committed but not acked
      ak0 = ack_cnt;
      drive(1'b1, 4'hF, 11'h030, 32'hCAFEF00D);
      tick();
      chk("abort.en0", 32'(EN0), 32'd1);
      chk("abort.we0", 32'(WE0), 32'hF);
      chk("abort.a0", 32'(A0), 32'd12);
      idle_bus();
      tick();
      tick();
      chk("abort.ack_t3", 32'(wb.wb_ack_o), 32'd0);
      tick();
      chk("abort.ack_t4", 32'(wb.wb_ack_o), 32'd0);
      chk("abort.acks", 32'(ack_cnt - ak0), 32'd0);
      chk("abort.dat", wb.wb_dat_o, held);
      xfer("rd30", 1'b0, 4'hF, 11'h030, 32'h0,
           4'h0, 9'd12, 32'hCAFEF00D, 1'b0);
      xfer("rd31", 1'b0, 4'hF, 11'h031, 32'h0,
           4'h0, 9'd12, 32'hCAFEF00D, 1'b0);
      xfer("rd33", 1'b0, 4'hF, 11'h033, 32'h0,
           4'h0, 9'd12, 32'hCAFEF00D, 1'b0);
      held = 32'hCAFEF00D;

      // reset during CAPTURE of a read
      ak0 = ack_cnt;
      drive(1'b0, 4'hF, 11'h010, 32'h0);
      tick();
      tick();
      chk("midrst.cap_ack", 32'(wb.wb_ack_o), 32'd0);
      RST = 1'b1;
      tick();
      chk("midrst.ack", 32'(wb.wb_ack_o), 32'd0);
      chk("midrst.dat", wb.wb_dat_o, 32'd0);
      chk("midrst.en0", 32'(EN0), 32'd0);
      chk("midrst.a0", 32'(A0), 32'd0);
      RST = 1'b0;
      idle_bus();
      tick();
      chk("midrst.idle_en0", 32'(EN0), 32'd0);
      chk("midrst.acks", 32'(ack_cnt - ak0), 32'd0);
      tick();
      xfer("postrst", 1'b0, 4'hF, 11'h010, 32'h0,
           4'h0, 9'd4, 32'hDEADBEEF, 1'b0);
      held = 32'hDEADBEEF;

      // write with no lanes selected is a harmless acked read
      xfer("fill40", 1'b1, 4'hF, 11'h040, 32'h5A5A5A5A,
           4'hF, 9'd16, held, 1'b0);
      xfer("sel0", 1'b1, 4'h0, 11'h040, 32'hFFFFFFFF,
           4'h0, 9'd16, held, 1'b0);
      xfer("rd40", 1'b0, 4'hF, 11'h040, 32'h0,
           4'h0, 9'd16, 32'h5A5A5A5A, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dffram_wb_ctrl.md
Name: dffram_wb_ctrl

Overview:
- Wishbone Classic slave front-end that owns the single port of the 512x32 latch-based DFFRAM macro.
- Converts bus cycles into one-cycle registered RAM strobes (EN0/WE0/A0/Di0).
- Captures read data from Do0 and returns a single-cycle acknowledge.
- Sits between the SoC bus interconnect and the RAM macro; one instance per RAM bank.

Parameters:
- AW, 9: RAM word-address width; depth = 2**AW words. Bus byte address is AW+2 bits.
- SW, 4: number of byte lanes; data width = 8*SW.

Ports:
- CLK  input  1  Clock for the block and the attached RAM.
- RST  input  1  Synchronous, active-high reset.
- wb_cyc_i  input  1  Bus cycle valid.
- wb_stb_i  input  1  Strobe; a request is cyc & stb.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_sel_i  input  SW  Byte-lane selects.
- wb_adr_i  input  AW+2  Byte address. Bits [1:0] are ignored; bits [AW+1:2] form the word address.
- wb_dat_i  input  8*SW  Write data.
- wb_dat_o  output  8*SW  Read data, registered.
- wb_ack_o  output  1  Transfer acknowledge, registered, one cycle wide.
- EN0  output  1  RAM enable.
- WE0  output  SW  RAM per-byte write enables.
- A0  output  AW  RAM word address.
- Di0  output  8*SW  RAM write data.
- Do0  input  8*SW  RAM read data. Valid in the cycle after an EN0 cycle; held until the next EN0.

Behaviour:
- All outputs are registered. Reset values: EN0=0, WE0=0, A0=0, Di0=0, wb_dat_o=0, wb_ack_o=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - When cyc&stb is seen in cycle T, register A0=adr[AW+1:2] and Di0=dat_i.
  - Register WE0 = we ? sel : 0, and EN0=1.
  - Go to ISSUE.
  - With no request, stay in IDLE with EN0=0 and WE0=0.
- ISSUE (T+1):
  - EN0, WE0, A0 and Di0 are presented for exactly this one cycle; the RAM acts at the end of this cycle.
  - At the end of the cycle, clear EN0 and WE0 and go to CAPTURE.
- CAPTURE (T+2):
  - For a read, Do0 is valid; latch it into wb_dat_o.
  - For a write, wb_dat_o holds its previous value.
  - If wb_cyc_i=1: set wb_ack_o for the next cycle and go to ACK.
  - If wb_cyc_i=0 (abort): go to IDLE with no ack.
- ACK (T+3):
  - wb_ack_o=1 for exactly this cycle.
  - Next state is IDLE; wb_ack_o returns to 0.
- Fixed latency: ack appears 3 cycles after the request cycle for both reads and writes. Maximum throughput is one transfer per 4 cycles.
- Back-to-back transfers:
  - A request still held during ACK is not re-sampled.
  - The next request is accepted in the following IDLE cycle. This is compliant because the master updates or drops stb after seeing ack.
- Abort: dropping cyc during ISSUE cannot cancel the RAM access; a write in ISSUE is committed. Only the ack is suppressed.
- Write with sel=0: EN0=1 and WE0=0 (a harmless read). Still acknowledged; wb_dat_o is not updated.
- Address: word address wraps modulo 2**AW. Byte-offset bits never alter A0.
- Reset mid-operation:
  - RST returns the FSM to IDLE and clears all outputs at the next edge. No ack is produced for the interrupted transfer.
  - A write whose ISSUE cycle coincides with RST is committed, because the RAM samples the already-driven strobes on that same edge.
- RST has priority over a simultaneous bus request; the request is not accepted in that cycle.

Test Plan:
- Write 0xDEADBEEF to byte addr 0x010 with sel=4'hF, then read 0x010 -> EN0 pulses once per transfer. WE0=4'hF on the write, 4'h0 on the read. A0=9'd4. Read ack at T+3 with wb_dat_o=0xDEADBEEF.
- Fill 0x11223344 at 0x020, write 0xAABBCCDD with sel=4'b0101, read back -> 0x11BB33DD. Write cycle shows WE0=4'b0101.
- Master holds cyc&stb for 3 consecutive reads of 0x000, 0x004, 0x7FC -> exactly 3 acks, each one cycle wide, spaced 4 cycles apart. A0 sequence is 0, 1, 511.
- Write at 0x030, drop cyc in the ISSUE cycle -> no ack. A later read of 0x030 returns the new data. Reads of 0x031/0x033 return the same word.
- Assert RST during CAPTURE of a read -> next cycle wb_ack_o=0, wb_dat_o=0, EN0=0, FSM in IDLE. A new read 2 cycles later completes normally with 3-cycle latency.
- Write with sel=4'h0 to 0x040 holding 0x5A5A5A5A, data 0xFFFFFFFF -> acked, WE0=0. Read returns 0x5A5A5A5A.
